tempo_clock: RTL and testbench

Programmable musical tempo generator: derives a tick stream of 16 ticks per quarter note (64th-note resolution) from the system clock using an exact phase accumulator, with runtime BPM, run/stop and phase sync. It emits single-cycle note-division strobes plus beat and bar position. It feeds sequencers, arpeggiators and envelope retrigger logic in the audio path, and supersedes fixed-BPM, fixed-oscillator tempo counters.

---
 rtl/tempo_clock.sv | 124 ++++++++++++
 tb/tb_tempo_clock.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/tempo_clock.sv
// tempo_clock: phase-accumulator tempo generator, 16 ticks per quarter note.
// Ports: clock_in/reset_n, bpm/run/sync in; tick/strobe/downbeat/beat/bar out.
module tempo_clock #(
  parameter int CLOCK_FREQ    = 12000000,
  parameter int BPM_WIDTH     = 9,
  parameter int BEATS_PER_BAR = 4,
  parameter int BAR_WIDTH     = 8
) (
  input  logic                 clock_in,
  input  logic                 reset_n,
  input  logic [BPM_WIDTH-1:0] bpm,
  input  logic                 run,
  input  logic                 sync,
  output logic                 tick,
  output logic [6:0]           strobe,
  output logic                 downbeat,
  output logic [3:0]           beat,
  output logic [BAR_WIDTH-1:0] bar
);

  localparam longint LIMIT   = longint'(60) * longint'(CLOCK_FREQ);
  localparam longint BPM_MAX = (longint'(1) << BPM_WIDTH) - 1;
  localparam int     ACC_W   = $clog2(LIMIT + 16 * BPM_MAX + 1);

  localparam logic [ACC_W-1:0] LIMIT_W   = ACC_W'(LIMIT);
  localparam logic [3:0]       BEAT_LAST = 4'(BEATS_PER_BAR - 1);

  if (16 * BPM_MAX >= LIMIT) begin : g_bad_rate
    $error("tempo_clock: max bpm too fast for CLOCK_FREQ");
  end

  if (BEATS_PER_BAR < 1 || BEATS_PER_BAR > 16) begin : g_bad_bar
    $error("tempo_clock: BEATS_PER_BAR out of range 1..16");
  end

  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     inc;
  logic [ACC_W-1:0]     sum;
  logic                 ovf;
  logic [BPM_WIDTH-1:0] bpm_l;
  logic                 pending;
  logic [5:0]           tcount;
  logic [5:0]           tc_nx;
  logic                 beat_wrap;
  logic                 bar_wrap;
  logic [3:0]           beat_nx;
  logic [6:0]           strobe_nx;

  always_comb begin
    inc       = ACC_W'({bpm_l, 4'b0000});
    sum       = acc + inc;
    ovf       = sum >= LIMIT_W;
    tc_nx     = tcount + 6'd1;
    beat_wrap = tc_nx[3:0] == 4'd0;
    bar_wrap  = beat_wrap && (beat == BEAT_LAST);
    beat_nx   = beat;
    if (bar_wrap) begin
      beat_nx = 4'd0;
    end else if (beat_wrap) begin
      beat_nx = beat + 4'd1;
    end
    // strobe[k] fires when the low k bits of the new position are zero
    strobe_nx = {tc_nx[5:0] == 6'd0,
                 tc_nx[4:0] == 5'd0,
                 tc_nx[3:0] == 4'd0,
                 tc_nx[2:0] == 3'd0,
                 tc_nx[1:0] == 2'd0,
                 tc_nx[0]   == 1'b0,
                 1'b1};
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      tcount   <= '0;
      beat     <= '0;
      bar      <= '0;
      bpm_l    <= '0;
      pending  <= 1'b1;
      tick     <= 1'b0;
      strobe   <= '0;
      downbeat <= 1'b0;
    end else begin
      tick     <= 1'b0;
      strobe   <= '0;
      downbeat <= 1'b0;
      if (!run) begin
        bpm_l <= bpm;
      end
      if (sync) begin
        acc     <= '0;
        tcount  <= '0;
        beat    <= '0;
        bar     <= '0;
        pending <= 1'b1;
      end else if (run && pending) begin
        // position is already 0 here: only reset/sync set pending
        pending  <= 1'b0;
        acc      <= '0;
        bpm_l    <= bpm;
        tick     <= 1'b1;
        strobe   <= 7'h7f;
        downbeat <= 1'b1;
      end else if (run && bpm_l != '0) begin
        if (ovf) begin
          // keep the remainder so long-term rate is exact
          acc      <= sum - LIMIT_W;
          bpm_l    <= bpm;
          tcount   <= tc_nx;
          beat     <= beat_nx;
          if (bar_wrap) begin
            bar <= bar + 1'b1;
          end
          tick     <= 1'b1;
          strobe   <= strobe_nx;
          downbeat <= beat_wrap && (beat_nx == 4'd0);
        end else begin
          acc <= sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_tempo_clock.sv
// tb_tempo_clock: directed checks of tempo_clock at CLOCK_FREQ=1000.
// Two instances: 4 beats per bar (a) and 3 beats per bar (b).
module tb_tempo_clock;

  logic       clk;
  logic       rst_n;
  logic [8:0] bpm;
  logic       run;
  logic       sync;

  logic       tick_a, tick_b;
  logic [6:0] strobe_a, strobe_b;
  logic       downbeat_a, downbeat_b;
  logic [3:0] beat_a, beat_b;
  logic [7:0] bar_a, bar_b;

  int checks;
  int failures;
  int n;
  int any_act;
  int cnt;

  tempo_clock #(
    .CLOCK_FREQ(1000), .BPM_WIDTH(9),
    .BEATS_PER_BAR(4), .BAR_WIDTH(8)
  ) u_a (
    .clock_in(clk), .reset_n(rst_n), .bpm(bpm),
    .run(run), .sync(sync), .tick(tick_a),
    .strobe(strobe_a), .downbeat(downbeat_a),
    .beat(beat_a), .bar(bar_a)
  );

  tempo_clock #(
    .CLOCK_FREQ(1000), .BPM_WIDTH(9),
    .BEATS_PER_BAR(3), .BAR_WIDTH(8)
  ) u_b (
    .clock_in(clk), .reset_n(rst_n), .bpm(bpm),
    .run(run), .sync(sync), .tick(tick_b),
    .strobe(strobe_b), .downbeat(downbeat_b),
    .beat(beat_b), .bar(bar_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // cycles (negedges) until tick_a is seen, bounded
  task automatic wait_tick(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!tick_a && cyc < 20000);
    chk("tick_timeout", 64'(tick_a), 64'(1));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    run      = 1'b0;
    sync     = 1'b0;
    bpm      = 9'd60;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_tick", 64'(tick_a), 64'(0));
    chk("rst_strobe", 64'(strobe_a), 64'(0));
    chk("rst_downbeat", 64'(downbeat_a), 64'(0));
    chk("rst_beat", 64'(beat_a), 64'(0));
    chk("rst_bar", 64'(bar_a), 64'(0));

    // first edge with run=1 gives the downbeat
    rst_n = 1'b1;
    run   = 1'b1;
    @(negedge clk);
    chk("db0_tick", 64'(tick_a), 64'(1));
    chk("db0_strobe", 64'(strobe_a), 64'(7'h7f));
    chk("db0_downbeat", 64'(downbeat_a), 64'(1));
    chk("db0_beat", 64'(beat_a), 64'(0));
    chk("db0_bar", 64'(bar_a), 64'(0));
    chk("db0_b_down", 64'(downbeat_b), 64'(1));

    // 64 ticks at 60 bpm: 63/62 alternating
    for (int i = 1; i <= 64; i++) begin
      wait_tick(n);
      chk("ivl60", 64'(n), 64'((i % 2 == 1) ? 63 : 62));
      chk("q_strobe", 64'(strobe_a[4]), 64'(i % 16 == 0));
      chk("a_down", 64'(downbeat_a), 64'(i % 64 == 0));
      chk("a_beat", 64'(beat_a), 64'((i / 16) % 4));
      chk("a_bar", 64'(bar_a), 64'(i / 64));
      chk("b_down", 64'(downbeat_b), 64'(i % 48 == 0));
      chk("b_whole", 64'(strobe_b[6]), 64'(i % 64 == 0));
      chk("b_bar", 64'(bar_b), 64'(i / 48));
    end

    // freeze mid-interval: acc=19200 after 20 cycles
    repeat (20) @(negedge clk);
    run     = 1'b0;
    any_act = 0;
    repeat (500) begin
      @(negedge clk);
      if (tick_a || strobe_a != 0 || downbeat_a || tick_b)
        any_act++;
    end
    chk("frozen_quiet", 64'(any_act), 64'(0));
    run = 1'b1;
    wait_tick(n);
    chk("resume_ivl", 64'(n), 64'(43));
    chk("resume_strobe", 64'(strobe_a), 64'(7'h01));
    chk("resume_down", 64'(downbeat_a), 64'(0));
    chk("resume_bar", 64'(bar_a), 64'(1));

    // tempo change mid-interval: current interval stays 62
    repeat (10) @(negedge clk);
    bpm = 9'd120;
    wait_tick(n);
    chk("chg_cur_ivl", 64'(n + 10), 64'(62));
    wait_tick(n);
    chk("ivl120_0", 64'(n), 64'(32));
    wait_tick(n);
    chk("ivl120_1", 64'(n), 64'(31));
    wait_tick(n);
    chk("ivl120_2", 64'(n), 64'(31));
    wait_tick(n);
    chk("ivl120_3", 64'(n), 64'(31));

    // advance from tick 70 to tick 352: bar 5, beat 2
    repeat (282) wait_tick(n);
    chk("pre_sync_bar", 64'(bar_a), 64'(5));
    chk("pre_sync_beat", 64'(beat_a), 64'(2));
    chk("pre_sync_strobe", 64'(strobe_a), 64'(7'h3f));
    repeat (5) @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    chk("sync_tick", 64'(tick_a), 64'(0));
    chk("sync_beat", 64'(beat_a), 64'(0));
    chk("sync_bar", 64'(bar_a), 64'(0));
    chk("sync_b_bar", 64'(bar_b), 64'(0));
    @(negedge clk);
    chk("sync_db_tick", 64'(tick_a), 64'(1));
    chk("sync_db_strobe", 64'(strobe_a), 64'(7'h7f));
    chk("sync_db_down", 64'(downbeat_a), 64'(1));
    chk("sync_db_b_down", 64'(downbeat_b), 64'(1));

    // sync on the overflow edge (32nd edge) wins
    repeat (31) @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    chk("sync_ovf_tick", 64'(tick_a), 64'(0));
    chk("sync_ovf_beat", 64'(beat_a), 64'(0));
    @(negedge clk);
    chk("sync_ovf_db", 64'(downbeat_a), 64'(1));

    // bpm=0 takes effect after the next tick
    bpm = 9'd0;
    wait_tick(n);
    chk("bpm0_last_ivl", 64'(n), 64'(32));
    cnt = 0;
    repeat (10000) begin
      @(negedge clk);
      if (tick_a) cnt++;
    end
    chk("bpm0_no_tick", 64'(cnt), 64'(0));

    // reload via run=0, then 15 ticks to tcount=16
    bpm = 9'd120;
    run = 1'b0;
    @(negedge clk);
    run = 1'b1;
    repeat (15) wait_tick(n);
    chk("pre_rst_beat", 64'(beat_a), 64'(1));
    chk("pre_rst_strobe", 64'(strobe_a), 64'(7'h1f));

    // asynchronous reset while tick is high
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tick", 64'(tick_a), 64'(0));
    chk("arst_strobe", 64'(strobe_a), 64'(0));
    chk("arst_beat", 64'(beat_a), 64'(0));
    chk("arst_b_beat", 64'(beat_b), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_tick", 64'(tick_a), 64'(1));
    chk("rst2_strobe", 64'(strobe_a), 64'(7'h7f));
    chk("rst2_down", 64'(downbeat_a), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
